// File: rtl/pkt_writer_if.sv
// pkt_writer_if: capture-stream and Avalon-MM write bus bundle.
// master = pkt_writer side, slave = stream source / memory bridge side.
interface pkt_writer_if #(
  parameter int N = 32
);
  localparam int B = N / 8;

  logic [N-1:0] s_data;
  logic         s_valid;
  logic         s_ready;
  logic [31:0]  avm_address;
  logic         avm_write;
  logic [N-1:0] avm_writedata;
  logic [B-1:0] avm_byteenable;
  logic         avm_waitrequest;

  modport master (
    input  s_data,
    input  s_valid,
    output s_ready,
    output avm_address,
    output avm_write,
    output avm_writedata,
    output avm_byteenable,
    input  avm_waitrequest
  );

  modport slave (
    output s_data,
    output s_valid,
    input  s_ready,
    input  avm_address,
    input  avm_write,
    input  avm_writedata,
    input  avm_byteenable,
    output avm_waitrequest
  );
endinterface

// File: rtl/pkt_writer.sv
// pkt_writer: Avalon-MM write master moving one stream packet to memory.
// Option macro PKT_WRITER_BYTEEN_EN trims byteenable on the final word.
module pkt_writer #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [31:0]  start_addr,
  input  logic [31:0]  pkt_len,
  input  logic         abort,
  pkt_writer_if.master bus,
  output logic [1:0]   state
);
  localparam int B  = N / 8;
  localparam int AW = $clog2(B);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_DONE = 2'b10,
    S_ERR  = 2'b11
  } state_t;

  state_t       r_state;
  state_t       w_next;
  logic [31:0]  r_addr;
  logic [N-1:0] r_data;
  logic [B-1:0] r_be;
  logic         r_write;
  logic [32:0]  r_nwords;
  logic [32:0]  r_acc;
  logic [32:0]  r_wcnt;
  logic         r_abort;

  logic [32:0]  w_nwords;
  logic         w_misalign;
  logic         w_wr_acc;
  logic         w_last_wr;
  logic         w_hs;
  logic         w_go;
  logic         w_last_word;
  logic         w_ready;
  logic         w_abort_req;
  logic [B-1:0] w_word_be;

  // 33-bit ceil(pkt_len / B) so a 0xFFFFFFFF length cannot overflow
  assign w_nwords    = ({1'b0, pkt_len} + 33'(B - 1)) >> AW;
  assign w_misalign  = |start_addr[AW-1:0];
  assign w_wr_acc    = r_write && !bus.avm_waitrequest;
  assign w_last_wr   = w_wr_acc && (r_wcnt + 33'd1 == r_nwords);
  assign w_hs        = bus.s_valid && w_ready;
  assign w_last_word = (r_acc + 33'd1 == r_nwords);
  assign w_abort_req = abort || r_abort;
  assign w_go        = (r_state != S_BUSY) && start
                    && !w_misalign && (pkt_len != 32'd0);

`ifdef PKT_WRITER_BYTEEN_EN
  logic [AW-1:0] r_tail;
  logic [B-1:0]  w_tail_be;

  // tail length is latched with the transfer so pkt_len may change later
  always_ff @(posedge clk) begin
    if (reset) r_tail <= '0;
    else if (w_go) r_tail <= pkt_len[AW-1:0];
  end

  // low (len mod B) lanes; a zero remainder means a full final word
  always_comb begin
    w_tail_be = '1;
    for (int i = 0; i < B; i++) begin
      w_tail_be[i] = (r_tail == '0) || (AW'(i) < r_tail);
    end
  end

  assign w_word_be = w_last_word ? w_tail_be : '1;
`else
  assign w_word_be = '1;
`endif

  // state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else r_state <= w_next;
  end

  // next state: abort waits until no write is left outstanding
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_BUSY: begin
        if (w_last_wr) begin
          w_next = S_DONE;
        end else if (w_abort_req && (!r_write || w_wr_acc)) begin
          w_next = S_ERR;
        end
      end
      default: begin
        if (start) begin
          if (w_misalign) w_next = S_ERR;
          else if (pkt_len == 32'd0) w_next = S_DONE;
          else w_next = S_BUSY;
        end
      end
    endcase
  end

  // outputs: status code and stream ready
  always_comb begin
    state   = r_state;
    w_ready = (r_state == S_BUSY)
           && (r_acc < r_nwords)
           && (!r_write || !bus.avm_waitrequest)
           && !abort
           && !r_abort;
  end

  // datapath: address/data/byteenable stay frozen while stalled
  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr   <= '0;
      r_data   <= '0;
      r_be     <= '1;
      r_write  <= 1'b0;
      r_nwords <= '0;
      r_acc    <= '0;
      r_wcnt   <= '0;
      r_abort  <= 1'b0;
    end else if (w_go) begin
      r_addr   <= start_addr;
      r_be     <= '1;
      r_write  <= 1'b0;
      r_nwords <= w_nwords;
      r_acc    <= '0;
      r_wcnt   <= '0;
      r_abort  <= 1'b0;
    end else if (r_state == S_BUSY) begin
      if (abort) r_abort <= 1'b1;
      if (w_wr_acc) begin
        r_addr <= r_addr + 32'(B);
        r_wcnt <= r_wcnt + 33'd1;
      end
      if (w_hs) begin
        r_data  <= bus.s_data;
        r_be    <= w_word_be;
        r_write <= 1'b1;
        r_acc   <= r_acc + 33'd1;
      end else if (w_wr_acc) begin
        r_write <= 1'b0;
      end
    end
  end

  assign bus.s_ready        = w_ready;
  assign bus.avm_address    = r_addr;
  assign bus.avm_write      = r_write;
  assign bus.avm_writedata  = r_data;
  assign bus.avm_byteenable = r_be;
endmodule

// File: tb/tb_pkt_writer.sv
// tb_pkt_writer: directed and randomized bench for pkt_writer.
// Expected writes come from a packet-level model of address/data/byteenable.
module tb_pkt_writer;
  localparam int N = 32;
  localparam int B = 4;
`ifdef PKT_WRITER_BYTEEN_EN
  localparam bit TAIL_EN = 1'b1;
`else
  localparam bit TAIL_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        abort;
  logic [31:0] start_addr;
  logic [31:0] pkt_len;
  logic [1:0]  state;

  int checks = 0;
  int errors = 0;
  int hs_cnt = 0;
  int hs_base = 0;

  logic [N-1:0] words [64];
  logic [31:0]  wa_q [$];
  logic [N-1:0] wd_q [$];
  logic [B-1:0] wb_q [$];

  pkt_writer_if #(.N(N)) bus ();

  pkt_writer #(.N(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .start_addr(start_addr),
    .pkt_len   (pkt_len),
    .abort     (abort),
    .bus       (bus),
    .state     (state)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!reset && bus.s_valid && bus.s_ready) hs_cnt++;
    if (!reset && bus.avm_write && !bus.avm_waitrequest) begin
      wa_q.push_back(bus.avm_address);
      wd_q.push_back(bus.avm_writedata);
      wb_q.push_back(bus.avm_byteenable);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    bus.s_data = words[(hs_cnt - hs_base) & 63];
  endtask

  task automatic begin_pkt(input logic [31:0] a, input logic [31:0] l);
    for (int i = 0; i < 64; i++) words[i] = $urandom;
    hs_base = hs_cnt;
    bus.s_data = words[0];
    start_addr = a;
    pkt_len = l;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_rand(input string tag);
    int c;
    c = 0;
    while (state == 2'b01 && c < 600) begin
      bus.s_valid = ($urandom_range(0, 3) != 0);
      bus.avm_waitrequest = ($urandom_range(0, 2) == 0);
      tick();
      c++;
    end
    bus.s_valid = 1'b0;
    bus.avm_waitrequest = 1'b0;
    chk({tag, "_budget"}, 64'(c < 600), 64'd1);
    tick();
  endtask

  function automatic logic [B-1:0] exp_be(int k, int nw, int l);
    if (TAIL_EN && k == nw - 1 && (l % B) != 0)
      return B'((1 << (l % B)) - 1);
    return '1;
  endfunction

  task automatic verify(input string tag, input logic [31:0] a,
                        input int l, input int w0);
    int nw;
    logic [31:0] ea;
    nw = (l + B - 1) / B;
    chk({tag, "_count"}, 64'(wa_q.size() - w0), 64'(nw));
    if (wa_q.size() - w0 == nw) begin
      for (int k = 0; k < nw; k++) begin
        ea = a + 32'(B * k);
        chk({tag, "_addr"}, 64'(wa_q[w0 + k]), 64'(ea));
        chk({tag, "_data"}, 64'(wd_q[w0 + k]), 64'(words[k]));
        chk({tag, "_be"}, 64'(wb_q[w0 + k]), 64'(exp_be(k, nw, l)));
      end
    end
  endtask

  initial begin
    int w0;
    logic [31:0] ra;
    int rl;

    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    start_addr = '0;
    pkt_len = '0;
    bus.s_valid = 1'b0;
    bus.s_data = '0;
    bus.avm_waitrequest = 1'b0;
    for (int i = 0; i < 64; i++) words[i] = '0;
    tick();
    tick();
    chk("rst_state", 64'(state), 64'd0);
    chk("rst_write", 64'(bus.avm_write), 64'd0);
    chk("rst_addr", 64'(bus.avm_address), 64'd0);
    chk("rst_data", 64'(bus.avm_writedata), 64'd0);
    chk("rst_be", 64'(bus.avm_byteenable), 64'hF);
    chk("rst_ready", 64'(bus.s_ready), 64'd0);
    reset = 1'b0;
    tick();

    // basic transfer: 3 words back to back
    w0 = wa_q.size();
    bus.s_valid = 1'b1;
    begin_pkt(32'h1000, 12);
    chk("basic_busy", 64'(state), 64'd1);
    chk("basic_ready", 64'(bus.s_ready), 64'd1);
    tick();
    for (int k = 0; k < 3; k++) begin
      chk("basic_wr", 64'(bus.avm_write), 64'd1);
      chk("basic_addr", 64'(bus.avm_address), 64'(32'h1000 + 4 * k));
      chk("basic_data", 64'(bus.avm_writedata), 64'(words[k]));
      tick();
    end
    chk("basic_done", 64'(state), 64'd2);
    chk("basic_wr_off", 64'(bus.avm_write), 64'd0);
    bus.s_valid = 1'b0;
    verify("basic", 32'h1000, 12, w0);

    // stall 3 cycles on the second write
    w0 = wa_q.size();
    bus.s_valid = 1'b1;
    begin_pkt(32'h1000, 12);
    tick();
    chk("stall_w0", 64'(bus.avm_address), 64'h1000);
    tick();
    bus.avm_waitrequest = 1'b1;
    #1;
    for (int c = 0; c < 4; c++) begin
      chk("stall_addr", 64'(bus.avm_address), 64'h1004);
      chk("stall_data", 64'(bus.avm_writedata), 64'(words[1]));
      chk("stall_ready", 64'(bus.s_ready), 64'd0);
      chk("stall_wr", 64'(bus.avm_write), 64'd1);
      if (c == 3) bus.avm_waitrequest = 1'b0;
      tick();
    end
    chk("stall_w2", 64'(bus.avm_address), 64'h1008);
    chk("stall_busy", 64'(state), 64'd1);
    tick();
    chk("stall_done", 64'(state), 64'd2);
    bus.s_valid = 1'b0;
    verify("stall", 32'h1000, 12, w0);

    // zero length
    w0 = wa_q.size();
    bus.s_valid = 1'b1;
    begin_pkt(32'h1000, 0);
    chk("len0_done", 64'(state), 64'd2);
    chk("len0_wr", 64'(bus.avm_write), 64'd0);
    tick();
    tick();
    chk("len0_count", 64'(wa_q.size() - w0), 64'd0);

    // misaligned address
    begin_pkt(32'h1002, 8);
    chk("misal_err", 64'(state), 64'd3);
    chk("misal_wr", 64'(bus.avm_write), 64'd0);
    tick();
    chk("misal_hold", 64'(state), 64'd3);
    bus.s_valid = 1'b0;

    // address wrap
    w0 = wa_q.size();
    bus.s_valid = 1'b1;
    begin_pkt(32'hFFFF_FFFC, 8);
    run_rand("wrap");
    chk("wrap_done", 64'(state), 64'd2);
    verify("wrap", 32'hFFFF_FFFC, 8, w0);

    // tail byteenable
    w0 = wa_q.size();
    bus.s_valid = 1'b1;
    begin_pkt(32'h1100, 6);
    run_rand("tail");
    verify("tail", 32'h1100, 6, w0);
    if (wa_q.size() - w0 == 2)
      chk("tail_be2", 64'(wb_q[w0 + 1]), TAIL_EN ? 64'h3 : 64'hF);

    // abort during a stalled write
    w0 = wa_q.size();
    bus.s_valid = 1'b1;
    bus.avm_waitrequest = 1'b0;
    begin_pkt(32'h2000, 20);
    tick();
    tick();
    bus.avm_waitrequest = 1'b1;
    abort = 1'b1;
    #1;
    chk("abort_ready", 64'(bus.s_ready), 64'd0);
    chk("abort_addr", 64'(bus.avm_address), 64'h2004);
    tick();
    chk("abort_busy", 64'(state), 64'd1);
    chk("abort_hold", 64'(bus.avm_address), 64'h2004);
    bus.avm_waitrequest = 1'b0;
    tick();
    chk("abort_err", 64'(state), 64'd3);
    chk("abort_wr", 64'(bus.avm_write), 64'd0);
    abort = 1'b0;
    tick();
    tick();
    tick();
    chk("abort_count", 64'(wa_q.size() - w0), 64'd2);
    chk("abort_stay", 64'(state), 64'd3);

    // restart from ERROR
    w0 = wa_q.size();
    begin_pkt(32'h3000, 20);
    run_rand("restart");
    chk("restart_done", 64'(state), 64'd2);
    verify("restart", 32'h3000, 20, w0);

    // reset mid-transfer while stalled
    bus.s_valid = 1'b1;
    begin_pkt(32'h4000, 16);
    tick();
    bus.avm_waitrequest = 1'b1;
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk("mrst_state", 64'(state), 64'd0);
    chk("mrst_wr", 64'(bus.avm_write), 64'd0);
    chk("mrst_addr", 64'(bus.avm_address), 64'd0);
    chk("mrst_ready", 64'(bus.s_ready), 64'd0);
    tick();
    chk("mrst_state2", 64'(state), 64'd0);
    reset = 1'b0;
    bus.avm_waitrequest = 1'b0;
    bus.s_valid = 1'b0;
    tick();

    // randomized packets
    for (int r = 0; r < 8; r++) begin
      ra = $urandom;
      ra[1:0] = 2'b00;
      if ($urandom_range(0, 2) == 0) ra = 32'hFFFF_FFF0;
      rl = $urandom_range(0, 40);
      w0 = wa_q.size();
      bus.s_valid = 1'b1;
      begin_pkt(ra, 32'(rl));
      run_rand("rand");
      chk("rand_done", 64'(state), 64'd2);
      verify("rand", ra, rl, w0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
